// File: rtl/cipher_frame_feeder.sv
// Byte feeder for a cipher core: small input FIFO, frame tracking with a
// FRAME_MAX length cap, and a two-stage output pipeline aligned to the core.
module cipher_frame_feeder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FRAME_MAX = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic [7:0]  core_data,
  output logic        core_en,
  output logic        ct_valid,
  output logic        ct_last,
  output logic [15:0] frame_len,
  output logic        frame_done,
  output logic        err_overlong
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [15:0]  FM16     = 16'(FRAME_MAX);

  typedef enum logic [1:0] {IDLE, ACTIVE, TRUNC} state_t;

  state_t        state, state_nxt;
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  logic          head_last;
  logic [7:0]    head_data;
  logic [15:0]   byte_cnt, cnt_nxt;
  logic          emit, at_max, end_frame, trunc_frame;
  logic          s1_last, s1_trunc;
  logic [15:0]   s1_len;

  // No pass-through: a full FIFO refuses input even if it pops this cycle.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign s_ready = reset_n & ~full;
  assign push    = s_valid & s_ready;
  assign pop     = ~empty;

  assign head_last = mem[rd_ptr][8];
  assign head_data = mem[rd_ptr][7:0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_last, s_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (pop) begin
      case (state)
        IDLE, ACTIVE: begin
          if (head_last)   state_nxt = IDLE;
          else if (at_max) state_nxt = TRUNC;
          else             state_nxt = ACTIVE;
        end
        TRUNC:   if (head_last) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM: outputs. A pop from IDLE starts a new frame at count 1.
  always_comb begin
    cnt_nxt     = (state == IDLE) ? 16'd1 : byte_cnt + 16'd1;
    at_max      = (cnt_nxt == FM16);
    emit        = pop && (state != TRUNC);
    end_frame   = emit && (head_last || at_max);
    trunc_frame = emit && !head_last && at_max;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) byte_cnt <= '0;
    else if (emit) byte_cnt <= cnt_nxt;
  end

  // Stage 1 feeds the core; stage 2 lines up with the core's data_out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_en      <= 1'b0;
      core_data    <= '0;
      s1_last      <= 1'b0;
      s1_trunc     <= 1'b0;
      s1_len       <= '0;
      ct_valid     <= 1'b0;
      ct_last      <= 1'b0;
      frame_done   <= 1'b0;
      err_overlong <= 1'b0;
      frame_len    <= '0;
    end else begin
      core_en      <= emit;
      core_data    <= emit ? head_data : '0;
      s1_last      <= end_frame;
      s1_trunc     <= trunc_frame;
      s1_len       <= cnt_nxt;
      ct_valid     <= core_en;
      ct_last      <= s1_last;
      frame_done   <= s1_last;
      err_overlong <= s1_trunc;
      if (s1_last) frame_len <= s1_len;
    end
  end

endmodule

// File: tb/tb_cipher_frame_feeder.sv
// Randomized bench for cipher_frame_feeder against a frame-rule reference model.
module tb_cipher_frame_feeder;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned FRAME_MAX = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic [7:0]  core_data;
  logic        core_en;
  logic        ct_valid;
  logic        ct_last;
  logic [15:0] frame_len;
  logic        frame_done;
  logic        err_overlong;

  cipher_frame_feeder #(.DEPTH(DEPTH), .FRAME_MAX(FRAME_MAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .core_data(core_data), .core_en(core_en),
    .ct_valid(ct_valid), .ct_last(ct_last), .frame_len(frame_len),
    .frame_done(frame_done), .err_overlong(err_overlong)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        emit;
    logic [7:0]  data;
    logic        last;
    logic        trunc;
    logic [15:0] len;
  } rec_t;

  rec_t        fq[$];
  rec_t        p1, p2;
  logic [15:0] exp_len;
  int          n_bytes;
  bit          discarding;
  bit          last_acc;
  int          n_checks;
  int          n_fail;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame rules applied in acceptance order: counts bytes, caps at FRAME_MAX,
  // and drops the remainder of an overlong frame up to its last byte.
  function automatic rec_t classify(input logic l, input logic [7:0] d);
    rec_t r;
    r = '0;
    if (discarding) begin
      if (l) discarding = 1'b0;
    end else begin
      n_bytes++;
      r.emit  = 1'b1;
      r.data  = d;
      r.last  = l || (n_bytes == FRAME_MAX);
      r.trunc = !l && (n_bytes == FRAME_MAX);
      r.len   = 16'(n_bytes);
      if (l) n_bytes = 0;
      else if (n_bytes == FRAME_MAX) begin
        discarding = 1'b1;
        n_bytes    = 0;
      end
    end
    return r;
  endfunction

  task automatic model_clear();
    fq.delete();
    p1 = '0;
    p2 = '0;
    exp_len    = '0;
    n_bytes    = 0;
    discarding = 1'b0;
  endtask

  // One clock: check outputs at the falling edge, advance the model, then
  // return just after the rising edge so the caller can drive new inputs.
  task automatic step();
    bit acc;
    @(negedge clk);
    if (!reset_n) begin
      check_eq("rst_s_ready",      16'(s_ready),      16'd0);
      check_eq("rst_core_en",      16'(core_en),      16'd0);
      check_eq("rst_core_data",    16'(core_data),    16'd0);
      check_eq("rst_ct_valid",     16'(ct_valid),     16'd0);
      check_eq("rst_ct_last",      16'(ct_last),      16'd0);
      check_eq("rst_frame_len",    frame_len,         16'd0);
      check_eq("rst_frame_done",   16'(frame_done),   16'd0);
      check_eq("rst_err_overlong", 16'(err_overlong), 16'd0);
      model_clear();
      last_acc = 1'b0;
    end else begin
      check_eq("s_ready",      16'(s_ready),   16'(fq.size() < DEPTH));
      check_eq("core_en",      16'(core_en),   16'(p1.emit));
      check_eq("core_data",    16'(core_data), p1.emit ? 16'(p1.data) : 16'd0);
      check_eq("ct_valid",     16'(ct_valid),  16'(p2.emit));
      check_eq("ct_last",      16'(ct_last),   16'(p2.emit && p2.last));
      check_eq("frame_done",   16'(frame_done), 16'(p2.emit && p2.last));
      check_eq("err_overlong", 16'(err_overlong), 16'(p2.emit && p2.trunc));
      if (p2.emit && p2.last) exp_len = p2.len;
      check_eq("frame_len",    frame_len,      exp_len);
      acc = s_valid && (fq.size() < DEPTH);
      p2 = p1;
      p1 = (fq.size() > 0) ? fq.pop_front() : rec_t'('0);
      if (acc) fq.push_back(classify(s_last, s_data));
      last_acc = acc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned cycles);
    s_valid = 1'b0;
    for (int unsigned i = 0; i < cycles; i++) step();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int unsigned waited;
    waited  = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    do begin
      step();
      waited++;
    end while (!last_acc && waited < 40);
    if (!last_acc) check_eq("accept_timeout", 16'(last_acc), 16'd1);
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input int unsigned len, input bit gaps);
    for (int unsigned i = 0; i < len; i++) begin
      if (gaps && $urandom_range(3) == 0) idle($urandom_range(1, 2));
      send_byte(8'($urandom), i == len - 1);
    end
  endtask

  task automatic pulse_reset(input int unsigned cycles);
    reset_n = 1'b0;
    s_valid = 1'b0;
    for (int unsigned i = 0; i < cycles; i++) step();
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    last_acc = 1'b0;
    model_clear();
    reset_n = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    for (int unsigned i = 0; i < 3; i++) step();
    reset_n = 1'b1;

    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    idle(4);

    send_byte(8'hA5, 1'b1);
    idle(4);

    for (int unsigned i = 0; i < 6; i++) send_byte(8'(8'h40 + i), i == 5);
    idle(4);

    for (int unsigned i = 0; i < FRAME_MAX; i++) send_byte(8'(8'h60 + i), i == FRAME_MAX - 1);
    idle(4);

    send_byte(8'hB1, 1'b0);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hB3, 1'b1);
    idle(1);
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b1);
    idle(4);

    send_byte(8'hD1, 1'b0);
    send_byte(8'hD2, 1'b0);
    pulse_reset(2);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b1);
    idle(4);

    for (int unsigned f = 0; f < 150; f++) begin
      send_frame($urandom_range(1, 7), 1'b1);
      if ($urandom_range(4) == 0) idle($urandom_range(1, 3));
    end
    idle(8);
    check_eq("drain_fifo", 16'(fq.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
